alu_seq: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle ALU. WIDTH-bit datapath with valid/ready handshakes and

---
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes, an iterative shifter retiring
// up to SHIFT_STEP bits per cycle, and registered result and flags.
module alu_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             msb_flag
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_COMP = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_DIFF = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [3:0]       op_q, op_n;
  logic [WIDTH-1:0] out_n;
  logic             carry_n, zero_n, msb_n;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] diff_idx, shifted;
  logic [CW-1:0]    step;

  // Arithmetic helpers and one shifter step of s = min(cnt, SHIFT_STEP)
  always_comb begin
    add_w    = {1'b0, in1} + {1'b0, in2};
    sub_w    = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
    diff_idx = WIDTH'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in1[i] != in2[i]) diff_idx = WIDTH'(i);
    end
    step = ({1'b0, cnt} < CW'(SHIFT_STEP)) ? {1'b0, cnt} : CW'(SHIFT_STEP);
    case (op_q)
      OP_SLL:  shifted = acc << step;
      OP_SRL:  shifted = acc >> step;
      OP_SRA:  shifted = $signed(acc) >>> step;
      default: shifted = acc;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    op_n    = op_q;
    out_n   = out;
    carry_n = carry_flag;
    zero_n  = zero_flag;
    msb_n   = msb_flag;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_n    = alu_op;
          zero_n  = (in1 == '0);
          msb_n   = in1[WIDTH-1];
          carry_n = 1'b0;
          state_n = DONE;
          case (alu_op)
            OP_ADD:  begin out_n = add_w[WIDTH-1:0]; carry_n = add_w[WIDTH]; end
            OP_SUB:  begin out_n = sub_w[WIDTH-1:0]; carry_n = sub_w[WIDTH]; end
            OP_COMP: out_n = '0 - in2;
            OP_SLL, OP_SRL, OP_SRA: begin
              acc_n = in1;
              cnt_n = in2[SHW-1:0];
              out_n = in1;
              if (in2[SHW-1:0] != '0) state_n = SHIFT;
            end
            OP_DIFF: out_n = diff_idx;
            OP_AND:  out_n = in1 & in2;
            OP_XOR:  out_n = in1 ^ in2;
            OP_OR:   out_n = in1 | in2;
            default: out_n = '0;
          endcase
        end
      end
      SHIFT: begin
        acc_n = shifted;
        cnt_n = cnt - SHW'(step);
        if (cnt == SHW'(step)) begin
          out_n   = shifted;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      op_q       <= '0;
      out        <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      msb_flag   <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      op_q       <= op_n;
      out        <= out_n;
      carry_flag <= carry_n;
      zero_flag  <= zero_n;
      msb_flag   <= msb_n;
      in_ready   <= (state_n == IDLE);
      out_valid  <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against a behavioural model,
// plus directed corner cases and a SHIFT_STEP=4 instance.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in1, in2, out;
  logic [3:0]  alu_op;
  logic        carry_flag, zero_flag, msb_flag;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] in1_4, in2_4, out4;
  logic [3:0]  alu_op4;
  logic        carry4, zero4, msb4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .msb_flag(msb_flag));

  alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in1(in1_4), .in2(in2_4), .alu_op(alu_op4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out(out4), .carry_flag(carry4),
    .zero_flag(zero4), .msb_flag(msb4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operands
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c);
    int sh;
    longint unsigned s;
    logic found;
    sh = int'(b % 32);
    r = 32'd0;
    c = 1'b0;
    case (op)
      4'd0: begin s = longint'(a) + longint'(b); r = s[31:0]; c = s[32]; end
      4'd1: r = 32'd0 - b;
      4'd2: r = a << sh;
      4'd3: r = a >> sh;
      4'd4: r = 32'($signed(a) >>> sh);
      4'd5: begin
        r = 32'd32;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
          if (!found && a[i] != b[i]) begin r = 32'(i); found = 1'b1; end
        end
      end
      4'd6: r = a & b;
      4'd7: r = a ^ b;
      4'd8: begin r = a - b; c = (a >= b); end
      4'd9: r = a | b;
      default: r = 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b, input int step);
    int sh;
    sh = int'(b % 32);
    if (op >= 4'd2 && op <= 4'd4 && sh != 0) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  // One transaction on dut: entry and exit at a negedge
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int gap, input int hold);
    logic [31:0] er;
    logic ec;
    int lat;
    logic busy_ok;
    model(op, a, b, er, ec);
    repeat (gap) @(negedge clk);
    check("idle_ready", in_ready, 1'b1);
    in_valid = 1'b1; in1 = a; in2 = b; alu_op = op;
    @(negedge clk);
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; alu_op = 4'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat(op, b, 1)));
    check("busy", {busy_ok, in_ready}, 2'b10);
    check("out", out, er);
    check("carry", carry_flag, ec);
    check("zero", zero_flag, (a == 32'd0));
    check("msb", msb_flag, a[31]);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      in1 = $urandom;
      @(negedge clk);
      check("hold_vld_rdy", {out_valid, in_ready}, 2'b10);
      check("hold_out", out, er);
      check("hold_flags", {carry_flag, zero_flag, msb_flag}, {ec, (a == 32'd0), a[31]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int lat;
    logic [31:0] er;
    logic ec;
    logic [3:0] op;
    logic [31:0] a, b;
    rst_n = 1'b0;
    in_valid = 1'b0; in1 = '0; in2 = '0; alu_op = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in1_4 = '0; in2_4 = '0; alu_op4 = '0; out_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", out, 32'd0);
    check("rst_flags", {carry_flag, zero_flag, msb_flag, out_valid}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1'b1);

    // Directed corner cases
    do_op(4'd0, 32'hFFFF_FFFF, 32'h1, 0, 0);
    check("add_const", out, 32'd0);
    do_op(4'd8, 32'd5, 32'd7, 1, 0);
    do_op(4'd4, 32'h8000_0000, 32'd4, 0, 0);
    do_op(4'd3, 32'h1234_5678, 32'h20, 0, 0);
    do_op(4'd5, 32'hF0, 32'h70, 0, 0);
    do_op(4'd5, 32'h1234, 32'h1234, 0, 0);
    do_op(4'd1, 32'd3, 32'd1, 0, 0);
    do_op(4'd12, 32'hDEAD_BEEF, 32'h1, 0, 0);
    do_op(4'd0, 32'd0, 32'd0, 0, 3);
    do_op(4'd2, 32'h8000_0001, 32'd31, 0, 3);

    // SHIFT_STEP=4 instance: SLL 1 by 31
    in_valid4 = 1'b1; in1_4 = 32'h1; in2_4 = 32'd31; alu_op4 = 4'd2;
    @(negedge clk);
    in_valid4 = 1'b0; in1_4 = $urandom; in2_4 = $urandom;
    lat = 1;
    while (!out_valid4 && lat < 200) begin @(negedge clk); lat++; end
    check("s4_latency", 64'(lat), 64'(exp_lat(4'd2, 32'd31, 4)));
    check("s4_out", out4, 32'h8000_0000);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("s4_release", {in_ready4, out_valid4}, 2'b10);

    // Reset during a shift aborts the op
    in_valid = 1'b1; in1 = 32'h8000_0001; in2 = 32'd20; alu_op = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out", out, 32'd0);
    check("midrst_flags", {carry_flag, zero_flag, msb_flag, out_valid}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(4'd2, 32'h0000_0003, 32'd20, 0, 0);

    // Random ops with handshake gaps
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 15) == 0) a = 32'd0;
      do_op(op, a, b, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
